delay_seq_driver: RTL and testbench

Stimulus generator that produces the two-signal temporal pattern `a ##N b` on request: it drives a single-cycle pulse on `a`, waits a programmable number of cycles, then holds `b` for a programmable number of cycles. It is the transmitting end of the `a`/`b` sequence interface whose receiving side is the `a ##1 b` / `a ##3 b` sequence detectors and cover properties. It sits in the bench and formal harness, feeding those detectors with legal, non-overlapping sequences.

---
 rtl/delay_seq_pkg.sv | 25 ++
 rtl/delay_seq_counter.sv | 30 +++
 rtl/delay_seq_driver.sv | 124 ++++++++++++
 tb/tb_delay_seq_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/delay_seq_pkg.sv
// Shared types and helpers for the a ##N b sequence driver.
package delay_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE_A = 3'd1,
    WAIT    = 3'd2,
    DRIVE_B = 3'd3,
    DONE    = 3'd4
  } state_e;

  // A zero distance is promoted to one so that a and b never overlap.
  function automatic int clamp_delay(input int val, input int max_val);
    if (val == 0) return 1;
    if (val > max_val) return max_val;
    return val;
  endfunction

  function automatic int clamp_blen(input int val, input int max_val);
    if (val == 0) return 1;
    if (val > max_val) return max_val;
    return val;
  endfunction

endpackage

// File: rtl/delay_seq_counter.sv
// Loadable down-counter; last flags the final count of a loaded interval.
module delay_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign last = (count_q == W'(1));

endmodule

// File: rtl/delay_seq_driver.sv
// Emits one a ##delay b sequence per accepted request; b is held b_len cycles.
//   state   | meaning
//   IDLE    | ready for a request
//   DRIVE_A | single-cycle a pulse
//   WAIT    | delay-1 gap cycles between a and b
//   DRIVE_B | b held for b_len cycles
//   DONE    | done pulse, b low before the next a
module delay_seq_driver
  import delay_seq_pkg::*;
#(
  parameter int MAX_DELAY = 8,
  parameter int MAX_B_LEN = 4,
  parameter int DELAY_W   = $clog2(MAX_DELAY + 1),
  parameter int BLEN_W    = $clog2(MAX_B_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [DELAY_W-1:0] delay,
  input  logic [BLEN_W-1:0]  b_len,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int CNT_W = (DELAY_W > BLEN_W) ? DELAY_W : BLEN_W;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [BLEN_W-1:0]  blen_q, blen_d;
  logic               cfg_err_d;
  logic               cnt_load, cnt_last;
  logic [CNT_W-1:0]   cnt_val;
  logic               a_q, b_q, busy_q, done_q, cfg_err_q, ready_q;
  logic               delay_bad, blen_bad;

  assign delay_bad = (delay == '0) || (int'(delay) > MAX_DELAY);
  assign blen_bad  = (b_len == '0) || (int'(b_len) > MAX_B_LEN);

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    blen_d    = blen_q;
    cfg_err_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d   = DRIVE_A;
          delay_d   = DELAY_W'(clamp_delay(int'(delay), MAX_DELAY));
          blen_d    = BLEN_W'(clamp_blen(int'(b_len), MAX_B_LEN));
          cfg_err_d = delay_bad || blen_bad;
        end
      end
      DRIVE_A: begin
        cnt_load = 1'b1;
        if (delay_q > DELAY_W'(1)) begin
          state_d = WAIT;
          cnt_val = CNT_W'(delay_q - DELAY_W'(1));
        end else begin
          state_d = DRIVE_B;
          cnt_val = CNT_W'(blen_q);
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_d  = DRIVE_B;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(blen_q);
        end
      end
      DRIVE_B: begin
        if (cnt_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  delay_seq_counter #(.W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      blen_q    <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      blen_q    <= blen_d;
      a_q       <= (state_d == DRIVE_A);
      b_q       <= (state_d == DRIVE_B);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      cfg_err_q <= cfg_err_d;
      ready_q   <= (state_d == IDLE);
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign start_ready = ready_q;

endmodule

// File: tb/tb_delay_seq_driver.sv
// Self-checking bench: per-cycle expected output records queued per request.
module tb_delay_seq_driver;

  localparam int MAX_DELAY = 8;
  localparam int MAX_B_LEN = 4;
  localparam int DW = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [DW-1:0] delay = '0;
  logic [BW-1:0] b_len = '0;
  logic          a, b, busy, done, cfg_err;

  int tests_run = 0;
  int tests_failed = 0;

  // record bits: {a, b, busy, done, cfg_err, start_ready}
  logic [5:0] exp_q[$];

  typedef struct {
    int d_in;
    int bl_in;
    int d_eff;
    int bl_eff;
    bit err;
  } vec_t;

  vec_t vecs[7];

  delay_seq_driver #(
    .MAX_DELAY (MAX_DELAY),
    .MAX_B_LEN (MAX_B_LEN),
    .DELAY_W   (DW),
    .BLEN_W    (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .delay       (delay),
    .b_len       (b_len),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    tests_run++;
    if (got != want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected trace of one sequence: cycles 0..d+bl, then the idle/ready cycle.
  function automatic void push_seq(input int d, input int bl, input bit err, input int ncyc);
    int l = d + bl;
    for (int k = 0; k < ncyc; k++) begin
      if (k <= l)
        exp_q.push_back({k == 0, (k >= d) && (k < l), 1'b1, k == l, (k == 0) && err, 1'b0});
      else
        exp_q.push_back(6'b000001);
    end
  endfunction

  task automatic run(input string name, input int drop_at, input int tog_hi,
                     input int rst_at, input int exp_d1, input int exp_d3);
    int n = exp_q.size();
    logic [3:0] a_hist = '0;
    logic prev_b = 1'b0;
    int d1 = 0;
    int d3 = 0;
    for (int i = 0; i < n; i++) begin
      logic [5:0] got, want;
      @(negedge clk);
      got  = {a, b, busy, done, cfg_err, start_ready};
      want = exp_q.pop_front();
      check({name, "_cycle"}, int'(got), int'(want));
      if (a) check({name, "_b_before_a"}, int'(prev_b), 0);
      if (b && a_hist[0]) d1++;
      if (b && a_hist[2]) d3++;
      a_hist = {a_hist[2:0], a};
      prev_b = b;
      if (i == drop_at) start_valid = 1'b0;
      if (i >= 1 && i <= tog_hi) start_valid = i[0];
      if (i == tog_hi + 1 && tog_hi > 0) start_valid = 1'b0;
      if (i == rst_at) rst = 1'b1;
      if (i == rst_at + 1) start_valid = 1'b1;
      if (i == rst_at + 2) begin
        rst = 1'b0;
        start_valid = 1'b0;
      end
    end
    check({name, "_det_a1b"}, d1, exp_d1);
    check({name, "_det_a3b"}, d3, exp_d3);
  endtask

  task automatic request(input int d, input int bl);
    start_valid = 1'b1;
    delay = DW'(d);
    b_len = BW'(bl);
  endtask

  initial begin
    int e1, e3;
    vecs[0] = '{1, 1, 1, 1, 1'b0};
    vecs[1] = '{3, 2, 3, 2, 1'b0};
    vecs[2] = '{0, 9, 1, 4, 1'b1};
    vecs[3] = '{8, 4, 8, 4, 1'b0};
    vecs[4] = '{12, 2, 8, 2, 1'b1};
    vecs[5] = '{2, 0, 2, 1, 1'b1};
    vecs[6] = '{5, 3, 5, 3, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", int'({a, b, busy, done, cfg_err, start_ready}), 6'b000001);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({a, b, busy, done, cfg_err, start_ready}), 6'b000001);

    foreach (vecs[j]) begin
      request(vecs[j].d_in, vecs[j].bl_in);
      push_seq(vecs[j].d_eff, vecs[j].bl_eff, vecs[j].err, vecs[j].d_eff + vecs[j].bl_eff + 2);
      e1 = (vecs[j].d_eff <= 1 && vecs[j].d_eff + vecs[j].bl_eff - 1 >= 1) ? 1 : 0;
      e3 = (vecs[j].d_eff <= 3 && vecs[j].d_eff + vecs[j].bl_eff - 1 >= 3) ? 1 : 0;
      run($sformatf("vec%0d", j), 0, 0, -10, e1, e3);
    end

    // Back-to-back with start_valid held: a in cycles 0, 5, 10.
    request(2, 1);
    for (int s = 0; s < 3; s++) push_seq(2, 1, 1'b0, 5);
    run("b2b", 10, 0, -10, 0, 0);

    // Requests toggled during WAIT and DRIVE_B are ignored.
    request(3, 3);
    push_seq(3, 3, 1'b0, 9);
    run("busy_toggle", 0, 5, -10, 0, 1);

    // Reset in cycle 2 of a delay=4 sequence, with a request during reset.
    request(4, 2);
    push_seq(4, 2, 1'b0, 3);
    for (int k = 0; k < 6; k++) exp_q.push_back(6'b000001);
    run("mid_reset", 0, 0, 2, 0, 0);

    // A normal request after the abort.
    request(3, 2);
    push_seq(3, 2, 1'b0, 7);
    run("post_reset", 0, 0, -10, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
